mantissa_addsub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor for the IEEE-format adder datapath, generalising the fixed 24-bit ripple add/sub. Operands are latched on a valid/ready handshake and processed DIGIT bits per clock, LSB first, with a registered inter-digit carry. This trades latency for a short critical path. An optional magnitude-correction pass returns |A−B| plus a sign flag, as required for mantissa subtraction before normalisation.

---
 rtl/mantissa_addsub_serial.sv | 138 +++++++++++++
 tb/tb_mantissa_addsub_serial.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_addsub_serial.sv
// mantissa_addsub_serial: digit-serial two's-complement add/sub, LSB first, registered inter-digit carry.
// Define ADDSUB_ABS_EN to add a serial negate pass that returns |A-B| with neg=1 on a borrowing subtract.
module mantissa_addsub_serial #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             neg
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
`ifdef ADDSUB_ABS_EN
    NEG  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, carry_q, carry_d, cout_q, cout_d, last, pass_neg;
  logic [DIGIT-1:0] x, y;
  logic [DIGIT:0] sum;
`ifdef ADDSUB_ABS_EN
  logic neg_q, neg_d;
  assign pass_neg = state_q == NEG;
  assign neg = neg_q;
`else
  assign pass_neg = 1'b0;
  assign neg = 1'b0;
`endif
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = res_q;
  assign cout = cout_q;
  // Operands and result shift right one digit per cycle, so the active digit always sits at bit 0.
  always_comb begin
    last = cnt_q == CW'(NDIG - 1);
    x = pass_neg ? ~res_q[DIGIT-1:0] : a_q[DIGIT-1:0];
    y = pass_neg ? '0 : b_q[DIGIT-1:0] ^ {DIGIT{op_q}};
    sum = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, carry_q};
    res_sh = WIDTH'({sum[DIGIT-1:0], res_q} >> DIGIT);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    res_d = res_q;
    cout_d = cout_q;
`ifdef ADDSUB_ABS_EN
    neg_d = neg_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = reg1;
        b_d = reg2;
        op_d = op;
        carry_d = op;
        cnt_d = '0;
        cout_d = 1'b0;
`ifdef ADDSUB_ABS_EN
        neg_d = 1'b0;
`endif
        state_d = ADD;
      end
      ADD: begin
        a_d = a_q >> DIGIT;
        b_d = b_q >> DIGIT;
        res_d = res_sh;
        carry_d = sum[DIGIT];
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          cout_d = sum[DIGIT];
          state_d = DONE;
`ifdef ADDSUB_ABS_EN
          if (op_q && !sum[DIGIT]) begin
            state_d = NEG;
            carry_d = 1'b1;
          end
`endif
        end
      end
`ifdef ADDSUB_ABS_EN
      NEG: begin
        res_d = res_sh;
        carry_d = sum[DIGIT];
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          neg_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      res_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      res_q <= res_d;
      cout_q <= cout_d;
    end
  end
`ifdef ADDSUB_ABS_EN
  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else neg_q <= neg_d;
  end
`endif
endmodule

// File: tb/tb_mantissa_addsub_serial.sv
// tb_mantissa_addsub_serial: scoreboard bench over five WIDTH/DIGIT configurations; config 0 is 24/4.
// Expectations follow ADDSUB_ABS_EN when the bench is compiled with it.
module tb_mantissa_addsub_serial;
  localparam int NC = 5;
  localparam int CFG_W [NC] = '{24, 24, 24, 8, 8};
  localparam int CFG_D [NC] = '{4, 1, 24, 1, 4};
  typedef struct packed {
    logic [23:0] r;
    logic        c;
    logic        n;
    logic [15:0] lat;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0] in_valid = '0, op = '0, out_ready = '0;
  logic [NC-1:0] in_ready, out_valid, cout, neg;
  logic [23:0] reg1 [NC];
  logic [23:0] reg2 [NC];
  logic [23:0] res [NC];
  obs_t sb [NC][$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : gc
    mantissa_addsub_serial #(.WIDTH(CFG_W[g]), .DIGIT(CFG_D[g])) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .reg1(reg1[g][CFG_W[g]-1:0]), .reg2(reg2[g][CFG_W[g]-1:0]), .op(op[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .result(res[g][CFG_W[g]-1:0]), .cout(cout[g]), .neg(neg[g])
    );
    if (CFG_W[g] < 24) begin : gp
      assign res[g][23:CFG_W[g]] = '0;
    end
  end
  function automatic obs_t model(int c, logic [23:0] a, logic [23:0] b, logic o);
    obs_t e;
    logic [24:0] s;
    logic [23:0] m;
    int w, nd;
    w = CFG_W[c];
    nd = CFG_W[c] / CFG_D[c];
    m = 24'hFFFFFF >> (24 - w);
    s = {1'b0, a & m} + {1'b0, (o ? ~b : b) & m} + 25'(o);
    e.c = s[w];
    e.r = s[23:0] & m;
    e.n = 1'b0;
    e.lat = 16'(nd);
`ifdef ADDSUB_ABS_EN
    if (o && !e.c) begin
      e.r = (~e.r + 24'd1) & m;
      e.n = 1'b1;
      e.lat = 16'(2 * nd);
    end
`endif
    return e;
  endfunction
  function automatic string fmt(obs_t o);
    return $sformatf("r=%h c=%b n=%b lat=%0d", o.r, o.c, o.n, o.lat);
  endfunction
  // Drives one operation, pushes its expectation, and returns what the DUT produced.
  task automatic run_op(input int c, input logic [23:0] a, input logic [23:0] b, input logic o, output obs_t g);
    for (int i = 0; i < 100 && !in_ready[c]; i++) @(negedge clk);
    reg1[c] = a;
    reg2[c] = b;
    op[c] = o;
    in_valid[c] = 1'b1;
    sb[c].push_back(model(c, a, b, o));
    @(posedge clk);
    #1 in_valid[c] = 1'b0;
    g.lat = 0;
    do begin
      @(posedge clk);
      g.lat++;
      @(negedge clk);
    end while (!out_valid[c] && g.lat < 200);
    g.r = res[c];
    g.c = cout[c];
    g.n = neg[c];
    out_ready[c] = 1'b1;
    @(posedge clk);
    #1 out_ready[c] = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      n_chk++;
      if ({in_ready[c], out_valid[c], res[c], cout[c], neg[c]} !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset cfg%0d: got rdy=%b vld=%b r=%h c=%b n=%b, want rdy=1 vld=0 r=0 c=0 n=0",
                 c, in_ready[c], out_valid[c], res[c], cout[c], neg[c]);
      end
    end
  endtask
  task automatic test_reset_wins;
    rst = 1'b1;
    in_valid[0] = 1'b1;
    reg1[0] = 24'h00000A;
    reg2[0] = 24'h000005;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({in_ready[0], out_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_wins: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready[0], out_valid[0]);
    end
  endtask
  task automatic test_add;
    obs_t g, e;
    run_op(0, 24'h000001, 24'hFFFFFF, 1'b0, g);
    e = sb[0].pop_front();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL add_wrap: got %s, want %s", fmt(g), fmt(e));
    end
  endtask
  task automatic test_sub;
    obs_t g, e;
    run_op(0, 24'h800000, 24'h000001, 1'b1, g);
    e = sb[0].pop_front();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL sub_pos: got %s, want %s", fmt(g), fmt(e));
    end
    run_op(0, 24'h000003, 24'h000005, 1'b1, g);
    e = sb[0].pop_front();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL sub_neg: got %s, want %s", fmt(g), fmt(e));
    end
  endtask
  task automatic test_backpressure;
    obs_t g, e;
    int idle_bad;
    reg1[0] = 24'h000005;
    reg2[0] = 24'h000007;
    op[0] = 1'b1;
    in_valid[0] = 1'b1;
    sb[0].push_back(model(0, 24'h000005, 24'h000007, 1'b1));
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    g.lat = 0;
    do begin
      @(posedge clk);
      g.lat++;
      @(negedge clk);
    end while (!out_valid[0] && g.lat < 200);
    e = sb[0].pop_front();
    for (int i = 0; i < 5; i++) begin
      g.r = res[0];
      g.c = cout[0];
      g.n = neg[0];
      n_chk++;
      if (g !== e || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: got %s rdy=%b vld=%b, want %s rdy=0 vld=1",
                 i, fmt(g), in_ready[0], out_valid[0], fmt(e));
      end
      in_valid[0] = i == 2;
      reg1[0] = 24'h111111;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) idle_bad++;
    end
    n_chk++;
    if (idle_bad != 0) begin
      n_fail++;
      $display("FAIL backpressure ignored_pulse: got %0d non-idle cycles after handshake, want 0", idle_bad);
    end
  endtask
  task automatic test_reset_mid;
    obs_t g, e;
    reg1[0] = 24'h123456;
    reg2[0] = 24'h111111;
    op[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({in_ready[0], out_valid[0], res[0], cout[0], neg[0]} !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b vld=%b r=%h c=%b n=%b, want rdy=1 vld=0 r=0 c=0 n=0",
               in_ready[0], out_valid[0], res[0], cout[0], neg[0]);
    end
    run_op(0, 24'h00000A, 24'h000005, 1'b0, g);
    e = sb[0].pop_front();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got %s, want %s", fmt(g), fmt(e));
    end
  endtask
  task automatic test_back_to_back;
    obs_t g, e;
    logic [23:0] ta [6] = '{24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 24'hABCDEF, 24'h400000};
    logic [23:0] tb [6] = '{24'hFFFFFF, 24'h000001, 24'h000001, 24'h000000, 24'hABCDEF, 24'hC00000};
    logic        to [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(0, ta[i], tb[i], to[i], g);
      e = sb[0].pop_front();
      n_chk++;
      if (g !== e || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back %0d: got %s rdy=%b vld=%b, want %s rdy=1 vld=0",
                 i, fmt(g), in_ready[0], out_valid[0], fmt(e));
      end
    end
  endtask
  task automatic test_sweep(input int c);
    obs_t g, e;
    logic [23:0] a, b;
    logic o;
    int sel;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      a = 24'($urandom);
      b = sel == 0 ? a : sel == 1 ? 24'hFFFFFF : sel == 2 ? 24'h0 : 24'($urandom);
      o = 1'($urandom_range(0, 1));
      run_op(c, a, b, o, g);
      e = sb[c].pop_front();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL sweep cfg%0d (W=%0d D=%0d) a=%h b=%h op=%b: got %s, want %s",
                 c, CFG_W[c], CFG_D[c], a, b, o, fmt(g), fmt(e));
      end
    end
  endtask
  initial begin
    for (int c = 0; c < NC; c++) begin
      reg1[c] = '0;
      reg2[c] = '0;
    end
    test_reset;
    test_reset_wins;
    test_add;
    test_sub;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    fork
      test_sweep(0);
      test_sweep(1);
      test_sweep(2);
      test_sweep(3);
      test_sweep(4);
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
